control_sequencer: RTL and testbench

//  Hardwired Moore control unit that sequences the datapath in place of a testbench FSM.

---
 rtl/control_sequencer_if.sv | 27 ++
 rtl/control_sequencer.sv | 174 +++++++++++++++++
 tb/tb_control_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath (or a bench standing in for it).
interface control_sequencer_if;
  logic       run;
  logic [4:0] ir_op;
  logic       con_ff;
  logic       busy;
  logic       incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read;
  logic       ram_read, ram_write, e_CON_FF, imm_sel;
  logic       Gra, Grb, Grc, e_Rin, e_Rout, BAout;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;

  modport master (
    input  run, ir_op, con_ff,
    output busy, incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read,
           ram_read, ram_write, e_CON_FF, imm_sel,
           Gra, Grb, Grc, e_Rin, e_Rout, BAout, ALU_op, BusDataSelect
  );

  modport slave (
    output run, ir_op, con_ff,
    input  busy, incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read,
           ram_read, ram_write, e_CON_FF, imm_sel,
           Gra, Grb, Grc, e_Rin, e_Rout, BAout, ALU_op, BusDataSelect
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch, decode and per-step control words for the datapath.
// Optional single-step mode via SEQ_SINGLE_STEP_EN (adds the step input and a STEP_WAIT state).
//
// state   | meaning
// IDLE    | waiting for run
// F0..F3  | fetch (FW stretches the memory read)
// DEC     | decode ir_op, pick execute path
// A1..A3  | ALU R-type
// L1,L2   | base + immediate into Z (ld, ldi, st)
// LI3     | ldi writeback
// L3      | address into MAR (ld, st)
// L4..L6  | ld memory read and writeback
// S4,S5   | st data into MDR, memory write
// B1..B4  | branch condition, target, conditional PC load
// STEP    | single-step pause after an instruction
module control_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic                clock,
  input  logic                clear,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  control_sequencer_if.master bus_if
);

  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_ZLO  = 5'b10011;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_C    = 5'b01100;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] WAIT_LD  = 4'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_F0, S_F1, S_FW, S_F2, S_F3, S_DEC,
    S_A1, S_A2, S_A3,
    S_L1, S_L2, S_LI3, S_L3, S_L4, S_L5, S_L6,
    S_S4, S_S5,
    S_B1, S_B2, S_B3, S_B4
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP
`endif
  } state_t;

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_DONE = S_STEP;
`else
  localparam state_t S_DONE = S_F0;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: if (bus_if.run) state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1: begin
        cnt_d   = WAIT_LD;
        state_d = (WAIT_LD == 4'd0) ? S_F2 : S_FW;
      end
      S_FW: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? S_F2 : S_FW;
      end
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        op_d = bus_if.ir_op;
        if (bus_if.ir_op >= 5'd3 && bus_if.ir_op <= 5'd8) state_d = S_A1;
        else begin
          case (bus_if.ir_op)
            5'd0, 5'd1, 5'd2: state_d = S_L1;
            5'd9:             state_d = S_B1;
            5'd27:            state_d = S_IDLE;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_A1:   state_d = S_A2;
      S_A2:   state_d = S_A3;
      S_A3:   state_d = S_DONE;
      S_L1:   state_d = S_L2;
      S_L2:   state_d = (op_q == 5'd1) ? S_LI3 : S_L3;
      S_LI3:  state_d = S_DONE;
      S_L3: begin
        cnt_d   = WAIT_LD;
        state_d = (op_q == 5'd2) ? S_S4 : S_L4;
      end
      S_L4: begin
        if (cnt_q == 4'd0) state_d = S_L5;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_L5:   state_d = S_L6;
      S_L6:   state_d = S_DONE;
      S_S4:   state_d = S_S5;
      S_S5:   state_d = S_DONE;
      S_B1:   state_d = S_B2;
      S_B2:   state_d = S_B3;
      S_B3:   state_d = S_B4;
      S_B4:   state_d = S_DONE;
`ifdef SEQ_SINGLE_STEP_EN
      S_STEP: if (step) state_d = S_F0;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control words decode from state only, except e_PC in B4 which follows con_ff.
  always_comb begin
    bus_if.busy          = (state_q != S_IDLE);
    bus_if.incPC         = 1'b0;
    bus_if.e_PC          = 1'b0;
    bus_if.e_IR          = 1'b0;
    bus_if.e_Y           = 1'b0;
    bus_if.e_Z           = 1'b0;
    bus_if.e_MAR         = 1'b0;
    bus_if.e_MDR         = 1'b0;
    bus_if.MDR_read      = 1'b0;
    bus_if.ram_read      = 1'b0;
    bus_if.ram_write     = 1'b0;
    bus_if.e_CON_FF      = 1'b0;
    bus_if.imm_sel       = 1'b0;
    bus_if.Gra           = 1'b0;
    bus_if.Grb           = 1'b0;
    bus_if.Grc           = 1'b0;
    bus_if.e_Rin         = 1'b0;
    bus_if.e_Rout        = 1'b0;
    bus_if.BAout         = 1'b0;
    bus_if.ALU_op        = 4'd0;
    bus_if.BusDataSelect = 5'd0;
    case (state_q)
      S_F0:  begin bus_if.BusDataSelect = BUS_PC; bus_if.e_MAR = 1'b1; bus_if.incPC = 1'b1; bus_if.e_Z = 1'b1; end
      S_F1:  begin bus_if.BusDataSelect = BUS_ZLO; bus_if.e_PC = 1'b1; bus_if.ram_read = 1'b1; end
      S_FW:  bus_if.ram_read = 1'b1;
      S_F2:  begin bus_if.MDR_read = 1'b1; bus_if.e_MDR = 1'b1; end
      S_F3:  begin bus_if.BusDataSelect = BUS_MDR; bus_if.e_IR = 1'b1; end
      S_A1:  begin bus_if.Grb = 1'b1; bus_if.e_Rout = 1'b1; bus_if.e_Y = 1'b1; end
      S_A2:  begin bus_if.Grc = 1'b1; bus_if.e_Rout = 1'b1; bus_if.ALU_op = op_q[3:0]; bus_if.e_Z = 1'b1; end
      S_A3, S_LI3: begin bus_if.BusDataSelect = BUS_ZLO; bus_if.Gra = 1'b1; bus_if.e_Rin = 1'b1; end
      S_L1:  begin bus_if.Grb = 1'b1; bus_if.BAout = 1'b1; bus_if.e_Rout = 1'b1; bus_if.e_Y = 1'b1; end
      S_L2, S_B3: begin
        bus_if.BusDataSelect = BUS_C; bus_if.imm_sel = 1'b1; bus_if.ALU_op = ALU_ADD; bus_if.e_Z = 1'b1;
      end
      S_L3:  begin bus_if.BusDataSelect = BUS_ZLO; bus_if.e_MAR = 1'b1; end
      S_L4:  bus_if.ram_read = 1'b1;
      S_L5:  begin bus_if.MDR_read = 1'b1; bus_if.e_MDR = 1'b1; end
      S_L6:  begin bus_if.BusDataSelect = BUS_MDR; bus_if.Gra = 1'b1; bus_if.e_Rin = 1'b1; end
      S_S4:  begin bus_if.Gra = 1'b1; bus_if.e_Rout = 1'b1; bus_if.e_MDR = 1'b1; end
      S_S5:  bus_if.ram_write = 1'b1;
      S_B1:  begin bus_if.Gra = 1'b1; bus_if.e_Rout = 1'b1; bus_if.e_CON_FF = 1'b1; end
      S_B2:  begin bus_if.BusDataSelect = BUS_PC; bus_if.e_Y = 1'b1; end
      S_B4:  begin bus_if.BusDataSelect = BUS_ZLO; bus_if.e_PC = bus_if.con_ff; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: random instruction streams checked cycle by cycle against
// a step-list model of each instruction's control words.
module tb_control_sequencer;
  localparam int MW = 3;
  localparam logic [4:0] PCOUT = 5'b10100, ZLO = 5'b10011, MDROUT = 5'b10101, COUT = 5'b01100;

  typedef struct packed {
    logic busy, incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read;
    logic ram_read, ram_write, e_CON_FF, imm_sel;
    logic Gra, Grb, Grc, e_Rin, e_Rout, BAout;
    logic [3:0] alu;
    logic [4:0] bsel;
  } cw_t;

  logic clock = 1'b0;
  logic clear;
`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  cw_t        exp_q[$];
  logic [4:0] op_q[$];
  logic       con_q[$];
  logic       run_q[$];

  control_sequencer_if dut_if();

  control_sequencer #(.MEM_WAIT(MW)) dut (
    .clock (clock),
    .clear (clear),
`ifdef SEQ_SINGLE_STEP_EN
    .step  (step),
`endif
    .bus_if(dut_if)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1);
  end

  function automatic cw_t observe();
    cw_t w;
    w.busy = dut_if.busy;         w.incPC = dut_if.incPC;       w.e_PC = dut_if.e_PC;
    w.e_IR = dut_if.e_IR;         w.e_Y = dut_if.e_Y;           w.e_Z = dut_if.e_Z;
    w.e_MAR = dut_if.e_MAR;       w.e_MDR = dut_if.e_MDR;       w.MDR_read = dut_if.MDR_read;
    w.ram_read = dut_if.ram_read; w.ram_write = dut_if.ram_write;
    w.e_CON_FF = dut_if.e_CON_FF; w.imm_sel = dut_if.imm_sel;
    w.Gra = dut_if.Gra;           w.Grb = dut_if.Grb;           w.Grc = dut_if.Grc;
    w.e_Rin = dut_if.e_Rin;       w.e_Rout = dut_if.e_Rout;     w.BAout = dut_if.BAout;
    w.alu = dut_if.ALU_op;        w.bsel = dut_if.BusDataSelect;
    return w;
  endfunction

  function automatic cw_t busy_word();
    cw_t w = '0;
    w.busy = 1'b1;
    return w;
  endfunction

  function automatic cw_t fetch_f0();
    cw_t w = busy_word();
    w.bsel = PCOUT; w.e_MAR = 1'b1; w.incPC = 1'b1; w.e_Z = 1'b1;
    return w;
  endfunction

  // One cycle of expectation; ir_op is random everywhere except the decode cycle.
  task automatic push(input cw_t w, input logic [4:0] ir, input logic con);
    exp_q.push_back(w);
    op_q.push_back(ir);
    con_q.push_back(con);
    run_q.push_back(1'($urandom));
  endtask

  task automatic push_plain(input cw_t w);
    push(w, 5'($urandom), 1'($urandom));
  endtask

  // Reference: the ordered list of control words an instruction produces.
  task automatic add_instr(input logic [4:0] op);
    cw_t w;
    logic c;
    push_plain(fetch_f0());
    for (int i = 0; i < MW; i++) begin
      w = busy_word(); w.ram_read = 1'b1;
      if (i == 0) begin w.bsel = ZLO; w.e_PC = 1'b1; end
      push_plain(w);
    end
    w = busy_word(); w.MDR_read = 1'b1; w.e_MDR = 1'b1; push_plain(w);
    w = busy_word(); w.bsel = MDROUT; w.e_IR = 1'b1; push_plain(w);
    push(busy_word(), op, 1'($urandom));
    if (op == 5'd27) return;
    if (op >= 5'd3 && op <= 5'd8) begin
      w = busy_word(); w.Grb = 1; w.e_Rout = 1; w.e_Y = 1; push_plain(w);
      w = busy_word(); w.Grc = 1; w.e_Rout = 1; w.alu = op[3:0]; w.e_Z = 1; push_plain(w);
      w = busy_word(); w.bsel = ZLO; w.Gra = 1; w.e_Rin = 1; push_plain(w);
    end else if (op <= 5'd2) begin
      w = busy_word(); w.Grb = 1; w.BAout = 1; w.e_Rout = 1; w.e_Y = 1; push_plain(w);
      w = busy_word(); w.bsel = COUT; w.imm_sel = 1; w.alu = 4'b0011; w.e_Z = 1; push_plain(w);
      w = busy_word(); w.bsel = ZLO;
      if (op == 5'd1) begin w.Gra = 1; w.e_Rin = 1; end else w.e_MAR = 1;
      push_plain(w);
      if (op == 5'd0) begin
        for (int i = 0; i < MW; i++) begin w = busy_word(); w.ram_read = 1; push_plain(w); end
        w = busy_word(); w.MDR_read = 1; w.e_MDR = 1; push_plain(w);
        w = busy_word(); w.bsel = MDROUT; w.Gra = 1; w.e_Rin = 1; push_plain(w);
      end else if (op == 5'd2) begin
        w = busy_word(); w.Gra = 1; w.e_Rout = 1; w.e_MDR = 1; push_plain(w);
        w = busy_word(); w.ram_write = 1; push_plain(w);
      end
    end else if (op == 5'd9) begin
      w = busy_word(); w.Gra = 1; w.e_Rout = 1; w.e_CON_FF = 1; push_plain(w);
      w = busy_word(); w.bsel = PCOUT; w.e_Y = 1; push_plain(w);
      w = busy_word(); w.bsel = COUT; w.imm_sel = 1; w.alu = 4'b0011; w.e_Z = 1; push_plain(w);
      c = 1'($urandom);
      w = busy_word(); w.bsel = ZLO; w.e_PC = c; push(w, 5'($urandom), c);
    end
`ifdef SEQ_SINGLE_STEP_EN
    push_plain(busy_word());
`endif
  endtask

  task automatic clear_queues();
    exp_q.delete(); op_q.delete(); con_q.delete(); run_q.delete();
  endtask

  // Starts from IDLE, plays the queued program and expects IDLE again after the final halt.
  task automatic run_program(input string name);
    cw_t got, w;
    int idx = 0;
    @(negedge clock);
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s idle_before: got %h required %h", name, got, cw_t'('0));
    end
    dut_if.run = 1'b1;
    @(posedge clock); #1;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      dut_if.ir_op  = op_q.pop_front();
      dut_if.con_ff = con_q.pop_front();
      dut_if.run    = run_q.pop_front();
      @(negedge clock);
      got = observe();
      n_checks++;
      if (got !== w) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h required %h", name, idx, got, w);
      end
      n_checks++;
      if ((got.ram_read && got.ram_write) || (got.bsel != 5'd0 && got.e_Rout)) begin
        n_fail++;
        $display("FAIL %s invariant cycle %0d: got %h required exclusive drivers", name, idx, got);
      end
      idx++;
      @(posedge clock); #1;
    end
    dut_if.run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL %s idle_after_halt: got %h required %h", name, got, cw_t'('0));
      end
    end
  endtask

  task automatic test_reset();
    cw_t got;
    clear = 1'b0; dut_if.run = 1'b0; dut_if.ir_op = 5'd0; dut_if.con_ff = 1'b0;
    #12;
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required %h", got, cw_t'('0));
    end
    @(negedge clock); clear = 1'b1;
    dut_if.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      got = observe();
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL idle_no_run: got %h required %h", got, cw_t'('0));
      end
    end
  endtask

  task automatic test_alu();
    clear_queues();
    for (int op = 3; op <= 8; op++) add_instr(5'(op));
    add_instr(5'd27);
    run_program("alu");
  endtask

  task automatic test_load_store();
    clear_queues();
    for (int i = 0; i < 6; i++) add_instr(5'($urandom_range(0, 2)));
    add_instr(5'd2);
    add_instr(5'd27);
    run_program("ld_ldi_st");
  endtask

  task automatic test_branch();
    clear_queues();
    for (int i = 0; i < 6; i++) add_instr(5'd9);
    add_instr(5'd27);
    run_program("branch");
  endtask

  task automatic test_nop_other();
    clear_queues();
    add_instr(5'd26);
    for (int i = 0; i < 4; i++) add_instr(5'($urandom_range(10, 25)));
    add_instr(5'($urandom_range(28, 31)));
    add_instr(5'd27);
    run_program("nop_other");
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    clear_queues();
    for (int i = 0; i < 16; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      add_instr(op);
    end
    add_instr(5'd27);
    run_program("back_to_back");
  endtask

  task automatic test_clear_mid_instr();
    cw_t got, w;
    clear_queues();
    add_instr(5'd9);
    @(negedge clock); dut_if.run = 1'b1;
    @(posedge clock); #1;
    dut_if.run = 1'b0;
    for (int i = 0; i < MW + 6; i++) begin
      void'(exp_q.pop_front());
      dut_if.ir_op  = op_q.pop_front();
      dut_if.con_ff = con_q.pop_front();
      @(posedge clock); #1;
    end
    w = exp_q.pop_front();
    got = observe();
    n_checks++;
    if (got !== w) begin
      n_fail++;
      $display("FAIL clear_b3_reached: got %h required %h", got, w);
    end
    #1 clear = 1'b0;
    #1 got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL clear_mid_b3: got %h required %h", got, cw_t'('0));
    end
    @(posedge clock); #1;
    got = observe();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL clear_held: got %h required %h", got, cw_t'('0));
    end
    clear = 1'b1;
    @(negedge clock); dut_if.run = 1'b1;
    @(posedge clock); #1;
    dut_if.run = 1'b0;
    @(negedge clock);
    got = observe();
    n_checks++;
    if (got !== fetch_f0()) begin
      n_fail++;
      $display("FAIL restart_f0: got %h required %h", got, fetch_f0());
    end
    clear = 1'b0;
    #2 clear = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_nop_other();
    test_back_to_back();
    test_clear_mid_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
